// File: rtl/fsk_pkg.sv
// Shared FSK constants and zero-crossing FSM encodings, common to the modulator and demodulator.
package fsk_pkg;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ARMED  = 2'd1,
        S_HIGH   = 2'd2
    } zc_state_t;

    // Tuning values the DDS modulator uses for the 100 Hz carrier and the per-key frequency step.
    localparam logic [31:0] CARRIER_TUNING_WORD = 32'd42949673;
    localparam logic [31:0] SIGNAL_STEP         = 32'd429497;

    localparam int DEFAULT_PERIOD_THRESH = 70;
    localparam int DEFAULT_HYST          = 8;
    localparam int DEFAULT_CONFIRM       = 3;
    localparam int DEFAULT_TIMEOUT       = 4000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fsk_zero_cross_det.sv
// Hysteresis zero-crossing detector: a three-state FSM plus a combinational rising-crossing pulse.
module fsk_zero_cross_det
    import fsk_pkg::*;
#(
    parameter int HYST = DEFAULT_HYST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic signed [7:0] fsk_in,
    input  logic              force_search,
    output logic              crossing
);

    // Compare at 9 bits so a hysteresis of 127 cannot wrap.
    localparam logic signed [8:0] HYST_POS = 9'(HYST);
    localparam logic signed [8:0] HYST_NEG = -HYST_POS;

    zc_state_t         state;
    logic signed [8:0] sample_ext;
    logic              below;
    logic              above;

    assign sample_ext = {fsk_in[7], fsk_in};
    assign below      = sample_ext < HYST_NEG;
    assign above      = sample_ext >= HYST_POS;
    assign crossing   = sample_en && (state == S_ARMED) && above;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SEARCH;
        end else if (sample_en) begin
            if (force_search) begin
                state <= S_SEARCH;
            end else begin
                case (state)
                    S_SEARCH: if (below) state <= S_ARMED;
                    S_ARMED:  if (above) state <= S_HIGH;
                    S_HIGH:   if (below) state <= S_ARMED;
                    default:  state <= S_SEARCH;
                endcase
            end
        end
    end

endmodule

// File: rtl/fsk_demodulation.sv
// Non-coherent FSK demodulator: period measurement, tone classification, debounce and loss detection.
// Optional macro FSK_DEMOD_STATS_EN adds a saturating symbol_changes counter of key_out transitions.
module fsk_demodulation
    import fsk_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int PERIOD_THRESH = DEFAULT_PERIOD_THRESH,
    parameter int HYST          = DEFAULT_HYST,
    parameter int CONFIRM       = DEFAULT_CONFIRM,
    parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic signed [7:0] fsk_in,
    output logic              key_out,
    output logic [CNT_W-1:0]  period,
    output logic              period_valid,
    output logic              locked,
    output logic              signal_lost
`ifdef FSK_DEMOD_STATS_EN
    ,
    output logic [15:0]       symbol_changes
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(PERIOD_THRESH);
    localparam logic [3:0]       CONFIRM_C = 4'(CONFIRM);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             have_ref;
    logic [3:0]       agree;
    logic [3:0]       agree_next;
    logic             prev_cls;
    logic             cls_new;
    logic             crossing;
    logic             timeout_hit;

    fsk_zero_cross_det #(
        .HYST(HYST)
    ) u_zero_cross (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .fsk_in      (fsk_in),
        .force_search(timeout_hit),
        .crossing    (crossing)
    );

    // The measured period includes the crossing sample itself, hence cnt + 1.
    assign cnt_next    = cnt + CNT_W'(1);
    assign cls_new     = cnt_next <= THRESH_C;
    assign agree_next  = (cls_new == prev_cls) ? ((agree >= CONFIRM_C) ? CONFIRM_C : agree + 4'd1)
                                               : 4'd1;
    assign timeout_hit = sample_en && !crossing && (cnt_next == TIMEOUT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            have_ref     <= 1'b0;
            agree        <= '0;
            prev_cls     <= 1'b0;
            key_out      <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            signal_lost  <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (sample_en) begin
                if (crossing) begin
                    cnt         <= '0;
                    have_ref    <= 1'b1;
                    signal_lost <= 1'b0;
                    if (have_ref) begin
                        period       <= cnt_next;
                        period_valid <= 1'b1;
                        prev_cls     <= cls_new;
                        agree        <= agree_next;
                        if (agree_next == CONFIRM_C) begin
                            key_out <= cls_new;
                            locked  <= 1'b1;
                        end
                    end
                end else if (timeout_hit) begin
                    cnt         <= TIMEOUT_C;
                    signal_lost <= 1'b1;
                    locked      <= 1'b0;
                    have_ref    <= 1'b0;
                    agree       <= '0;
                end else if (cnt != TIMEOUT_C) begin
                    cnt <= cnt_next;
                end
            end
        end
    end

`ifdef FSK_DEMOD_STATS_EN
    logic key_update;

    assign key_update = crossing && have_ref && (agree_next == CONFIRM_C) && (cls_new != key_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            symbol_changes <= '0;
        end else if (key_update) begin
            symbol_changes <= sat_inc16(symbol_changes);
        end
    end
`endif

endmodule

// File: doc/fsk_demodulation.md
Name: fsk_demodulation

Overview:
- Non-coherent FSK demodulator; the receive-side counterpart of the team's DDS-based FSK modulator.
- Takes the modulator's signed 8-bit cosine sample stream and measures the carrier period between rising zero crossings.
- Classifies each period as the high tone (key=1) or the low tone (key=0), debounces the decision, and flags loss of signal.
- Sits directly after the sample source (modulator loopback or ADC front end); its output drives the bit-recovery logic.

Parameters:
- CNT_W, 24, width of the period counter and of the period output.
- PERIOD_THRESH, 70, period in accepted samples; a period <= PERIOD_THRESH is the high tone (key=1), otherwise the low tone (key=0).
- HYST, 8, crossing hysteresis magnitude (signed sample units, 0..127).
- CONFIRM, 3, number of consecutive equal classifications required before key_out changes (1..15).
- TIMEOUT, 4000, sample count without a rising crossing that declares signal loss (must be < 2^CNT_W).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  qualifies fsk_in; all counting and state advance only on cycles where sample_en=1.
- fsk_in  input  8  signed two's-complement sample.
- key_out  output  1  recovered, debounced key.
- period  output  CNT_W  last measured period; updated only when period_valid=1.
- period_valid  output  1  one-cycle pulse when a new period is captured.
- locked  output  1  high once CONFIRM consecutive equal classifications have been seen and no timeout has occurred since.
- signal_lost  output  1  sticky high after a timeout; cleared by the next rising crossing.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: key_out=0, period=0, period_valid=0, locked=0, signal_lost=0, FSM=S_SEARCH, counters=0, have_ref=0.
- FSM states; all transitions happen only when sample_en=1:
  - S_SEARCH: go to S_ARMED when fsk_in < -HYST.
  - S_ARMED: when fsk_in >= +HYST, a rising crossing event occurs; go to S_HIGH.
  - S_HIGH: go to S_ARMED when fsk_in < -HYST.
  - Samples inside [-HYST, +HYST) never change state. Signed compare is done at 9 bits so HYST=127 does not overflow.
- Period counter: increments by 1 per accepted sample and saturates at TIMEOUT.
- On a rising crossing:
  - If have_ref=1: the value captured is counter+1 (the count includes the crossing sample). It is registered into period, with period_valid pulsed in the next clk cycle; that is 1-cycle latency from the crossing sample.
  - Counter resets to 0, have_ref is set to 1, and signal_lost is cleared.
  - The first crossing after reset or after a timeout only sets the reference; it produces no period_valid.
- Classification on each period_valid:
  - cls = (period <= PERIOD_THRESH).
  - If cls equals the previous cls, the agreement count increments, saturating at CONFIRM; otherwise the agreement count is set to 1.
  - When the agreement count reaches CONFIRM: key_out <= cls and locked <= 1, in the same cycle as the update.
- Timeout: when the counter reaches TIMEOUT, the block:
  - sets signal_lost=1, locked=0, have_ref=0;
  - clears the agreement count;
  - forces the FSM to S_SEARCH;
  - leaves key_out holding its last value.
- If a crossing and the timeout fall on the same sample, the crossing wins and no timeout is declared.
- sample_en=0: all state holds, and period_valid is 0.
- Reset asserted mid-period: everything returns to reset values immediately; the first post-reset crossing is reference-only.

Optional Feature:
- Macro: FSK_DEMOD_STATS_EN.
- When defined, the block adds output port symbol_changes (16 bits).
  - It is a saturating count of key_out transitions, saturating at 16'hFFFF.
  - It is reset to 0 by rst_n.
- When undefined, the port and its counter are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package fsk_pkg holds:
  - FSM state encodings S_SEARCH/S_ARMED/S_HIGH;
  - the default carrier and threshold constants shared with the modulator (carrier 100 Hz tuning word 32'd42949673, signal step 32'd429497).
- One sub-module, fsk_zero_cross_det: the hysteresis FSM plus the crossing pulse. Period measurement, classification and timeout stay in the top level.

Test Plan:
- Square-like input alternating +100/-100 every 20 samples (period 40) -> period_valid pulses with period=40; key_out=1 and locked=1 after the 4th crossing (reference + 3 periods).
- Switch the input to period 100 -> period=100; key_out goes to 0 exactly on the 3rd period of 100; locked stays 1.
- Alternate 40 and 100 periods every crossing -> key_out never changes; the agreement count never exceeds 1.
- Noise of ±5 around 0 superimposed on zero dwell, HYST=8 -> no extra crossings; period is unchanged.
- Hold fsk_in=0 for 4000 samples after lock -> signal_lost=1 and locked=0 at sample 4000; key_out held; the next crossing clears signal_lost with no period_valid.
- Assert rst_n low mid-period, then toggle sample_en at 50% duty -> all outputs return to reset values; periods are counted in accepted samples only (period 40 measured over 80 clocks).
